rom_arbiter: RTL

//  Shares one synchronous single-port ROM (1-clock read latency, q registered on clock) between two

---
 rtl/rom_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one synchronous single-port ROM (1-clock read latency)
// between two requesters. A request sampled in IDLE is granted, its address
// registered onto rom_a, the ROM word captured two edges later and returned
// with a one-cycle ack pulse; one access takes 4 clocks.
// Optional build macro ROM_ARB_FIXED_PRIO_EN: port 0 always wins ties
// (default, macro undefined: round robin on ties).
module rom_arbiter #(
    parameter  int unsigned KB = 64,
    localparam int unsigned AW = $clog2(KB * 1024)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic [AW-1:0] a0,
    output logic          ack0,
    output logic [7:0]    q0,
    input  logic          req1,
    input  logic [AW-1:0] a1,
    output logic          ack1,
    output logic [7:0]    q1,
    output logic          busy,
    output logic [AW-1:0] rom_a,
    input  logic [7:0]    rom_q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_LATCH = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_grant;
    logic [AW-1:0] r_rom_a;
    logic          r_ack0;
    logic          r_ack1;
    logic [7:0]    r_q0;
    logic [7:0]    r_q1;
    logic          r_busy;
`ifndef ROM_ARB_FIXED_PRIO_EN
    logic          r_last;
`endif

    logic          w_any;
    logic          w_win;
    logic [AW-1:0] w_addr;

    assign w_any  = req0 | req1;
    assign w_addr = w_win ? a1 : a0;

`ifdef ROM_ARB_FIXED_PRIO_EN
    // Fixed priority: port 1 wins only when port 0 is not requesting
    always_comb begin
        w_win = ~req0;
    end
`else
    // Round robin: on a tie the port not served last wins
    always_comb begin
        if (req0 && req1) begin
            w_win = ~r_last;
        end else begin
            w_win = ~req0;
        end
    end
`endif

    // Access sequencer: grant, ROM read, data capture, ack pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_rom_a <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_q0    <= '0;
            r_q1    <= '0;
            r_busy  <= 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
            r_last  <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_rom_a <= w_addr;
                        r_grant <= w_win;
`ifndef ROM_ARB_FIXED_PRIO_EN
                        r_last  <= w_win;
`endif
                        r_busy  <= 1'b1;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    if (r_grant) begin
                        r_q1   <= rom_q;
                        r_ack1 <= 1'b1;
                    end else begin
                        r_q0   <= rom_q;
                        r_ack0 <= 1'b1;
                    end
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0  = r_ack0;
    assign ack1  = r_ack1;
    assign q0    = r_q0;
    assign q1    = r_q1;
    assign busy  = r_busy;
    assign rom_a = r_rom_a;

endmodule
